// File: rtl/tick_countdown_timer.sv
// Tick-driven guess countdown timer.
// Counts whole units down from a loaded value and flags expiry.
module tick_countdown_timer #(
  parameter int TICKS_PER_UNIT = 50,
  parameter int MAX_VALUE      = 99
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [6:0] remaining,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse
);

  localparam int SW =
    (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [SW-1:0] SUB_MAX =
    SW'(TICKS_PER_UNIT - 1);
  localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          pulse_q, pulse_d;
  logic [6:0]    sat_val;
  logic [6:0]    tens_w;
  logic [6:0]    ones_w;

  assign sat_val =
    (load_value > MAX_V) ? MAX_V : load_value;

  // State, counters and expiry pulse register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sub_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sub_q   <= sub_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: clear > load > pause > start
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sub_d   = sub_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      rem_d   = '0;
      sub_d   = '0;
    end else if (load) begin
      state_d = IDLE;
      rem_d   = sat_val;
      sub_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start && rem_q != '0)
            state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick_in) begin
            if (sub_q == SUB_MAX) begin
              sub_d = '0;
              if (rem_q <= 7'd1) begin
                rem_d   = '0;
                state_d = DONE;
                pulse_d = 1'b1;
              end else begin
                rem_d = rem_q - 7'd1;
              end
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!pause && start)
            state_d = RUN;
        end
        DONE: begin
          rem_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Display digits follow the registered count directly
  always_comb begin
    tens_w   = rem_q / 7'd10;
    ones_w   = rem_q % 7'd10;
    bcd_tens = tens_w[3:0];
    bcd_ones = ones_w[3:0];
  end

  assign remaining    = rem_q;
  assign running      = (state_q == RUN);
  assign expired      = (state_q == DONE);
  assign expire_pulse = pulse_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer.
// Main instance uses 4 ticks/unit, second uses 1.
module tb_tick_countdown_timer;

  logic       clock;
  logic       reset_n;
  logic       tick_in;
  logic       load;
  logic [6:0] load_value;
  logic       start;
  logic       pause;
  logic       clear;

  logic [6:0] rem4, rem1;
  logic [3:0] tens4, ones4, tens1, ones1;
  logic       run4, exp4, pul4;
  logic       run1, exp1, pul1;

  int checks = 0;
  int errors = 0;

  tick_countdown_timer #(
    .TICKS_PER_UNIT(4),
    .MAX_VALUE(99)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick_in(tick_in),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .clear(clear),
    .remaining(rem4),
    .bcd_tens(tens4),
    .bcd_ones(ones4),
    .running(run4),
    .expired(exp4),
    .expire_pulse(pul4)
  );

  tick_countdown_timer #(
    .TICKS_PER_UNIT(1),
    .MAX_VALUE(99)
  ) dut1 (
    .clock(clock),
    .reset_n(reset_n),
    .tick_in(tick_in),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .clear(clear),
    .remaining(rem1),
    .bcd_tens(tens1),
    .bcd_ones(ones1),
    .running(run1),
    .expired(exp1),
    .expire_pulse(pul1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic do_load(input logic [6:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
    end
    tick_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rem4, tens4, ones4} !== 15'd0) begin
      errors++;
      $display("FAIL reset_rem rem=%0d t=%0d o=%0d exp 0/0/0",
               rem4, tens4, ones4);
    end
    checks++;
    if ({run4, exp4, pul4} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000",
               {run4, exp4, pul4});
    end
    checks++;
    if ({rem1, run1, exp1, pul1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut1 rem=%0d flags=%b exp 0/000",
               rem1, {run1, exp1, pul1});
    end
  endtask

  task automatic test_countdown();
    int pcnt;
    logic [6:0] e;
    pcnt = 0;
    do_load(7'd3);
    do_start();
    checks++;
    if (run4 !== 1'b1 || rem4 !== 7'd3) begin
      errors++;
      $display("FAIL cd_start run=%b rem=%0d exp 1/3",
               run4, rem4);
    end
    for (int k = 1; k <= 12; k++) begin
      tick_in = 1'b1;
      step();
      pcnt += int'(pul4);
      e = 7'(3 - k / 4);
      checks++;
      if (rem4 !== e) begin
        errors++;
        $display("FAIL cd_tick%0d rem=%0d exp=%0d",
                 k, rem4, e);
      end
    end
    tick_in = 1'b0;
    checks++;
    if (pul4 !== 1'b1 || exp4 !== 1'b1 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL cd_done p=%b e=%b r=%b exp 1/1/0",
               pul4, exp4, run4);
    end
    step();
    pcnt += int'(pul4);
    step();
    pcnt += int'(pul4);
    checks++;
    if (pcnt !== 1) begin
      errors++;
      $display("FAIL cd_pulsecount got=%0d exp=1", pcnt);
    end
    checks++;
    if (exp4 !== 1'b1 || tens4 !== 4'd0 || ones4 !== 4'd0) begin
      errors++;
      $display("FAIL cd_hold e=%b t=%0d o=%0d exp 1/0/0",
               exp4, tens4, ones4);
    end
  endtask

  task automatic test_load_bcd();
    do_load(7'd120);
    checks++;
    if (rem4 !== 7'd99 || tens4 !== 4'd9 || ones4 !== 4'd9) begin
      errors++;
      $display("FAIL sat rem=%0d t=%0d o=%0d exp 99/9/9",
               rem4, tens4, ones4);
    end
    checks++;
    if (exp4 !== 1'b0 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_idle e=%b r=%b exp 0/0",
               exp4, run4);
    end
    do_load(7'd47);
    checks++;
    if (rem4 !== 7'd47 || tens4 !== 4'd4 || ones4 !== 4'd7) begin
      errors++;
      $display("FAIL bcd47 rem=%0d t=%0d o=%0d exp 47/4/7",
               rem4, tens4, ones4);
    end
    do_load(7'd99);
    checks++;
    if (rem4 !== 7'd99) begin
      errors++;
      $display("FAIL load99 rem=%0d exp=99", rem4);
    end
  endtask

  task automatic test_pause();
    do_load(7'd2);
    do_start();
    do_ticks(2);
    do_pause();
    checks++;
    if (run4 !== 1'b0 || rem4 !== 7'd2) begin
      errors++;
      $display("FAIL pz_enter r=%b rem=%0d exp 0/2",
               run4, rem4);
    end
    do_ticks(10);
    checks++;
    if (rem4 !== 7'd2 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL pz_ignore rem=%0d r=%b exp 2/0",
               rem4, run4);
    end
    do_start();
    do_ticks(2);
    checks++;
    if (rem4 !== 7'd1 || run4 !== 1'b1) begin
      errors++;
      $display("FAIL pz_resume rem=%0d r=%b exp 1/1",
               rem4, run4);
    end
  endtask

  task automatic test_priority();
    do_load(7'd5);
    do_start();
    do_ticks(1);
    pause = 1'b1;
    tick_in = 1'b1;
    step();
    pause = 1'b0;
    tick_in = 1'b0;
    checks++;
    if (run4 !== 1'b0 || rem4 !== 7'd5) begin
      errors++;
      $display("FAIL pr_pause r=%b rem=%0d exp 0/5",
               run4, rem4);
    end
    do_start();
    do_ticks(2);
    checks++;
    if (rem4 !== 7'd5) begin
      errors++;
      $display("FAIL pr_subheld2 rem=%0d exp=5", rem4);
    end
    do_ticks(1);
    checks++;
    if (rem4 !== 7'd4) begin
      errors++;
      $display("FAIL pr_subheld3 rem=%0d exp=4", rem4);
    end
    clear = 1'b1;
    load = 1'b1;
    load_value = 7'd9;
    step();
    clear = 1'b0;
    load = 1'b0;
    checks++;
    if (rem4 !== 7'd0 || run4 !== 1'b0 || pul4 !== 1'b0) begin
      errors++;
      $display("FAIL pr_clear rem=%0d r=%b p=%b exp 0/0/0",
               rem4, run4, pul4);
    end
    do_start();
    checks++;
    if (run4 !== 1'b0) begin
      errors++;
      $display("FAIL pr_start0 r=%b exp=0", run4);
    end
  endtask

  task automatic test_done_reset();
    do_load(7'd1);
    do_start();
    do_ticks(4);
    start = 1'b1;
    tick_in = 1'b1;
    step();
    step();
    start = 1'b0;
    tick_in = 1'b0;
    checks++;
    if (exp4 !== 1'b1 || rem4 !== 7'd0 ||
        run4 !== 1'b0 || pul4 !== 1'b0) begin
      errors++;
      $display("FAIL dn_hold e=%b rem=%0d r=%b p=%b exp 1/0/0/0",
               exp4, rem4, run4, pul4);
    end
    do_load(7'd5);
    checks++;
    if (exp4 !== 1'b0 || rem4 !== 7'd5 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL dn_reload e=%b rem=%0d r=%b exp 0/5/0",
               exp4, rem4, run4);
    end
    do_start();
    do_ticks(2);
    reset_n = 1'b0;
    step();
    checks++;
    if ({rem4, tens4, ones4, run4, exp4, pul4} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid rem=%0d flags=%b exp 0/000",
               rem4, {run4, exp4, pul4});
    end
    reset_n = 1'b1;
    do_load(7'd1);
    do_start();
    do_ticks(3);
    checks++;
    if (rem4 !== 7'd1 || exp4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_sub rem=%0d e=%b exp 1/0",
               rem4, exp4);
    end
  endtask

  task automatic test_tpu1();
    do_reset();
    do_load(7'd1);
    do_start();
    do_ticks(1);
    checks++;
    if (exp1 !== 1'b1 || pul1 !== 1'b1 || rem1 !== 7'd0) begin
      errors++;
      $display("FAIL t1_done e=%b p=%b rem=%0d exp 1/1/0",
               exp1, pul1, rem1);
    end
    step();
    checks++;
    if (pul1 !== 1'b0 || exp1 !== 1'b1) begin
      errors++;
      $display("FAIL t1_pulse p=%b e=%b exp 0/1",
               pul1, exp1);
    end
    do_load(7'd3);
    do_start();
    do_ticks(1);
    checks++;
    if (rem1 !== 7'd2 || run1 !== 1'b1) begin
      errors++;
      $display("FAIL t1_dec rem=%0d r=%b exp 2/1",
               rem1, run1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tick_in = 1'b0;
    load = 1'b0;
    load_value = '0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    test_reset();
    test_countdown();
    test_load_bcd();
    test_pause();
    test_priority();
    test_done_reset();
    test_tpu1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
